// File: rtl/eth_header_parser.sv
// eth_header_parser: registered Ethernet II / 802.3 header field extractor.
// Captures an 18-byte header snapshot and latches MACs, type and VLAN info.
module eth_header_parser #(
  parameter logic [15:0] TPID_VLAN         = 16'h8100,
  parameter logic [15:0] TPID_QINQ         = 16'h88A8,
  parameter logic [15:0] LEN_TYPE_BOUNDARY = 16'h0600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  header_bytes [0:17],
  input  logic        header_valid,
  output logic [47:0] dest_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype_raw,
  output logic        fields_valid,
  output logic        vlan_present,
  output logic [15:0] vlan_tci,
  output logic [15:0] ethertype,
  output logic        is_length,
  output logic [4:0]  hdr_len,
  output logic        parse_done
);

  logic [47:0] nx_dest;
  logic [47:0] nx_src;
  logic [15:0] nx_raw;
  logic        nx_vlan;
  logic [15:0] nx_tci;
  logic [15:0] nx_type;
  logic        nx_is_len;
  logic [4:0]  nx_hdr_len;

  // Decode every field from the current snapshot so one capture stays coherent.
  always_comb begin
    nx_dest    = '0;
    nx_src     = '0;
    nx_raw     = '0;
    nx_vlan    = 1'b0;
    nx_tci     = '0;
    nx_type    = '0;
    nx_is_len  = 1'b0;
    nx_hdr_len = 5'd14;

    nx_dest = {header_bytes[0], header_bytes[1],
               header_bytes[2], header_bytes[3],
               header_bytes[4], header_bytes[5]};
    nx_src  = {header_bytes[6],  header_bytes[7],
               header_bytes[8],  header_bytes[9],
               header_bytes[10], header_bytes[11]};
    nx_raw  = {header_bytes[12], header_bytes[13]};

    nx_vlan = (nx_raw == TPID_VLAN) ||
              (nx_raw == TPID_QINQ);

    // Only one tag level: an inner TPID is passed through untouched.
    if (nx_vlan) begin
      nx_tci     = {header_bytes[14], header_bytes[15]};
      nx_type    = {header_bytes[16], header_bytes[17]};
      nx_hdr_len = 5'd18;
    end else begin
      nx_tci     = '0;
      nx_type    = nx_raw;
      nx_hdr_len = 5'd14;
    end

    nx_is_len = (nx_type < LEN_TYPE_BOUNDARY);
  end

  // Field registers: reset clears, a valid strobe loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_mac      <= '0;
      src_mac       <= '0;
      ethertype_raw <= '0;
      vlan_present  <= 1'b0;
      vlan_tci      <= '0;
      ethertype     <= '0;
      is_length     <= 1'b0;
      hdr_len       <= '0;
    end else if (header_valid) begin
      dest_mac      <= nx_dest;
      src_mac       <= nx_src;
      ethertype_raw <= nx_raw;
      vlan_present  <= nx_vlan;
      vlan_tci      <= nx_tci;
      ethertype     <= nx_type;
      is_length     <= nx_is_len;
      hdr_len       <= nx_hdr_len;
    end
  end

  // Status flags: sticky capture indicator and per-capture done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      fields_valid <= 1'b0;
      parse_done   <= 1'b0;
    end else begin
      fields_valid <= fields_valid | header_valid;
      parse_done   <= header_valid;
    end
  end

endmodule

// File: tb/tb_eth_header_parser.sv
// tb_eth_header_parser: table-driven scoreboard bench
// for the Ethernet header field extractor.
module tb_eth_header_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  hb [0:17];
  logic        header_valid;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype_raw;
  logic        fields_valid;
  logic        vlan_present;
  logic [15:0] vlan_tci;
  logic [15:0] ethertype;
  logic        is_length;
  logic [4:0]  hdr_len;
  logic        parse_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eth_header_parser dut (
    .clk           (clk),
    .rst           (rst),
    .header_bytes  (hb),
    .header_valid  (header_valid),
    .dest_mac      (dest_mac),
    .src_mac       (src_mac),
    .ethertype_raw (ethertype_raw),
    .fields_valid  (fields_valid),
    .vlan_present  (vlan_present),
    .vlan_tci      (vlan_tci),
    .ethertype     (ethertype),
    .is_length     (is_length),
    .hdr_len       (hdr_len),
    .parse_done    (parse_done)
  );

  typedef struct packed {
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [15:0] raw;
    logic        vlan;
    logic [15:0] tci;
    logic [15:0] et;
    logic        islen;
    logic [4:0]  hlen;
  } exp_t;

  typedef struct {
    string        name;
    logic [143:0] hdr;
    exp_t         exp;
  } vec_t;

  exp_t q[$];
  exp_t last_e;
  vec_t vecs[8];

  function automatic vec_t mk(
    input string nm,
    input logic [47:0] dm, input logic [47:0] sm,
    input logic [15:0] raw, input logic [31:0] tail,
    input logic vl, input logic [15:0] tci,
    input logic [15:0] et, input logic il,
    input logic [4:0] hl);
    vec_t v;
    v.name = nm;
    v.hdr  = {dm, sm, raw, tail};
    v.exp  = '{dmac: dm, smac: sm, raw: raw,
               vlan: vl, tci: tci, et: et,
               islen: il, hlen: hl};
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic chk_all(input string nm, input exp_t e,
                         input logic fv);
    chk({nm, ".dmac"}, dest_mac, e.dmac);
    chk({nm, ".smac"}, src_mac, e.smac);
    chk({nm, ".raw"},  ethertype_raw, e.raw);
    chk({nm, ".vlan"}, vlan_present, e.vlan);
    chk({nm, ".tci"},  vlan_tci, e.tci);
    chk({nm, ".et"},   ethertype, e.et);
    chk({nm, ".isln"}, is_length, e.islen);
    chk({nm, ".hlen"}, hdr_len, e.hlen);
    chk({nm, ".fv"},   fields_valid, fv);
  endtask

  task automatic drive(input logic [143:0] h,
                       input logic v, input logic r);
    @(negedge clk);
    for (int i = 0; i < 18; i++) hb[i] = h[143-8*i -: 8];
    header_valid = v;
    rst = r;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Drive one capture, push its expectation, pop and compare after the edge.
  task automatic capture(input string nm,
                         input logic [143:0] h,
                         input exp_t e);
    drive(h, 1'b1, 1'b0);
    q.push_back(e);
    settle();
    chk({nm, ".pd"}, parse_done, 1'b1);
    if (q.size() == 0) begin
      chk({nm, ".sb"}, 1, 0);
    end else begin
      last_e = q.pop_front();
      chk_all(nm, last_e, 1'b1);
    end
  endtask

  task automatic idle_check(input string nm,
                            input logic [143:0] h);
    drive(h, 1'b0, 1'b0);
    settle();
    chk({nm, ".pd"}, parse_done, 1'b0);
    chk_all(nm, last_e, 1'b1);
  endtask

  task automatic zero_check(input string nm);
    exp_t z;
    z = '0;
    chk_all(nm, z, 1'b0);
    chk({nm, ".pd"}, parse_done, 1'b0);
  endtask

  initial begin
    logic [143:0] h;
    exp_t e;

    vecs[0] = mk("plain", 48'hFFFFFFFFFFFF, 48'h001122334455,
                 16'h0800, 32'h00000000,
                 1'b0, 16'h0000, 16'h0800, 1'b0, 5'd14);
    vecs[1] = mk("vlan", 48'h010203040506, 48'h0A0B0C0D0E0F,
                 16'h8100, 32'hA00586DD,
                 1'b1, 16'hA005, 16'h86DD, 1'b0, 5'd18);
    vecs[2] = mk("qinq", 48'h0200000000AA, 48'h0200000000BB,
                 16'h88A8, 32'h01230800,
                 1'b1, 16'h0123, 16'h0800, 1'b0, 5'd18);
    vecs[3] = mk("len5ff", 48'h112233445566, 48'h665544332211,
                 16'h05FF, 32'hDEADBEEF,
                 1'b0, 16'h0000, 16'h05FF, 1'b1, 5'd14);
    vecs[4] = mk("typ600", 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6,
                 16'h0600, 32'hFFFFFFFF,
                 1'b0, 16'h0000, 16'h0600, 1'b0, 5'd14);
    vecs[5] = mk("vlnlen", 48'h00000000000F, 48'hF00000000000,
                 16'h8100, 32'h00640040,
                 1'b1, 16'h0064, 16'h0040, 1'b1, 5'd18);
    vecs[6] = mk("inner", 48'h123456789ABC, 48'hCBA987654321,
                 16'h88A8, 32'h00058100,
                 1'b1, 16'h0005, 16'h8100, 1'b0, 5'd18);
    vecs[7] = mk("t9100", 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D,
                 16'h9100, 32'h12345678,
                 1'b0, 16'h0000, 16'h9100, 1'b0, 5'd14);

    rst = 1'b1;
    header_valid = 1'b1;
    for (int i = 0; i < 18; i++) hb[i] = 8'h5A;
    settle();
    settle();
    zero_check("reset");

    drive(vecs[0].hdr, 1'b0, 1'b0);
    settle();
    zero_check("post_rst_idle");

    // Plain capture, then hold with churning bytes.
    capture(vecs[0].name, vecs[0].hdr, vecs[0].exp);
    for (int i = 0; i < 3; i++) begin
      h = {$urandom, $urandom, $urandom, $urandom, $urandom};
      idle_check($sformatf("hold%0d", i), h);
    end

    for (int i = 1; i < 8; i++)
      capture(vecs[i].name, vecs[i].hdr, vecs[i].exp);
    idle_check("hold_tail", vecs[0].hdr);

    // Reset and valid together: reset wins.
    drive(vecs[1].hdr, 1'b1, 1'b1);
    settle();
    zero_check("rst_vs_valid");

    capture("after_rst", vecs[2].hdr, vecs[2].exp);
    drive(vecs[3].hdr, 1'b0, 1'b0);
    settle();
    chk("after_rst.pd_drop", parse_done, 1'b0);
    chk_all("after_rst.hold", vecs[2].exp, 1'b1);

    // Three back-to-back captures with distinct source MACs.
    for (int i = 0; i < 3; i++) begin
      e = vecs[0].exp;
      e.smac = 48'h020000000010 + 48'(i);
      h = vecs[0].hdr;
      h[95:48] = e.smac;
      capture($sformatf("b2b%0d", i), h, e);
    end
    idle_check("b2b_end", vecs[4].hdr);

    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_header_parser.md
Name: eth_header_parser

Overview:
- Registered Ethernet header field extractor.
- Accepts an 18-byte header snapshot (14-byte Ethernet II/802.3 header plus an optional 4-byte 802.1Q/802.1ad tag) on a valid strobe.
- Latches destination MAC, source MAC, raw EtherType and the derived VLAN/type classification.
- Sits between the byte-capture front end and the L3 dispatch logic of the packet parser.

Parameters:
- TPID_VLAN, 16'h8100, first TPID value recognised as a VLAN tag.
- TPID_QINQ, 16'h88A8, second TPID value recognised as a VLAN tag.
- LEN_TYPE_BOUNDARY, 16'h0600, values below this are 802.3 length fields rather than EtherTypes.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- header_bytes  input  18x8 (unpacked [0:17] of byte)  header bytes in wire order; byte 0 is the first byte received.
- header_valid  input  1  capture strobe, sampled at the rising edge.
- dest_mac  output  48  bytes 0..5; byte 0 in bits [47:40].
- src_mac  output  48  bytes 6..11; byte 6 in bits [47:40].
- ethertype_raw  output  16  {byte12, byte13}.
- fields_valid  output  1  high once any header has been captured since reset.
- vlan_present  output  1  ethertype_raw equals TPID_VLAN or TPID_QINQ.
- vlan_tci  output  16  {byte14, byte15} when vlan_present, else 0.
- ethertype  output  16  effective type: {byte16, byte17} when vlan_present, else ethertype_raw.
- is_length  output  1  ethertype < LEN_TYPE_BOUNDARY.
- hdr_len  output  5  header length in bytes: 18 when vlan_present, else 14.
- parse_done  output  1  one-cycle pulse, one cycle after each capture.

Behaviour:
- Reset is synchronous and active-high (rst): every output clears to 0, including hdr_len.
- rst high takes priority over header_valid on the same edge: nothing is captured.
- Capture happens at a rising edge with header_valid=1 and rst=0. All outputs update at that edge, so latency is 1 cycle and outputs are visible after the edge.
- All outputs are computed from the same header_bytes sample; there is no mixing across captures.
- With header_valid=0, header_bytes is ignored. Every field output holds its last captured value, and parse_done drops to 0.
- Byte order is big-endian throughout: the lower byte index maps to the more significant bits.
- VLAN detection uses ethertype_raw only. A single tag level is parsed; an inner TPID in bytes 16..17 is reported as-is in ethertype, with no further decode.
- When vlan_present=0, bytes 14..17 do not affect any output.
- is_length is evaluated on the effective ethertype, as an unsigned compare. Value 16'h05FF gives 1; 16'h0600 gives 0.
- fields_valid is sticky: it is set by the first capture and cleared only by rst. It stays high after header_valid drops.
- parse_done is high for exactly the one cycle following each capture edge. Back-to-back valid cycles keep it high continuously, and each cycle overwrites all fields.
- Reset mid-stream clears all outputs. The next capture behaves as the first capture after reset.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then capture bytes FF×6, 00 11 22 33 44 55, 08 00, 00 00 00 00 -> dest_mac=FFFFFFFFFFFF, src_mac=001122334455, ethertype_raw=0800, ethertype=0800, vlan_present=0, vlan_tci=0, hdr_len=14, is_length=0, fields_valid=1. Drop header_valid for 3 cycles -> all values held, parse_done=0.
2. Capture bytes 12..17 = 81 00 A0 05 86 DD -> vlan_present=1, vlan_tci=A005, ethertype=86DD, ethertype_raw=8100, hdr_len=18. Repeat with 88 A8 -> vlan_present=1.
3. Capture ethertype_raw=05FF -> is_length=1. Capture ethertype_raw=0600 -> is_length=0. Capture tagged frame with inner bytes 00 40 -> is_length=1.
4. Assert rst and header_valid in the same cycle -> all outputs 0, fields_valid=0. Release rst, capture once -> parse_done high exactly one cycle.
5. header_valid high on 3 consecutive cycles with different src_mac values -> src_mac tracks each with 1-cycle latency, parse_done high for 3 consecutive cycles.
6. Change header_bytes while header_valid=0 -> no output changes.
